// File: rtl/ram_32768x3_if.sv
// ram_32768x3_if: access bus of the board colour RAM (address, write data/enable, read data, ready)
interface ram_32768x3_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 3
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic              wren;
  logic [DATA_W-1:0] q;
  logic              ready;
  modport master (output address, data, wren, input q, ready);
  modport slave  (input address, data, wren, output q, ready);
endinterface

// File: rtl/ram_32768x3.sv
// ram_32768x3: single-port 32768x3 board colour RAM that self-clears after reset
module ram_32768x3 #(
  parameter int                ADDR_W      = 15,
  parameter int                DATA_W      = 3,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input logic          clock,
  input logic          reset,
  ram_32768x3_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {CLEAR, RUN} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready_q, ready_d, qen_q, qen_d, hit_q, hit_d;
  logic [DATA_W-1:0] wd_q, wd_d, mem_rd;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wdat;
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      qen_q   <= 1'b0;
      hit_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      qen_q   <= qen_d;
      hit_q   <= hit_d;
      wd_q    <= wd_d;
    end
  end
  always_comb begin
    state_d = (state_q == CLEAR && cnt_q == ADDR_W'(DEPTH - 1)) ? RUN : state_q;
    cnt_d   = (state_q == CLEAR) ? cnt_q + 1'b1 : cnt_q;
  end
  // q is forced to zero until the first RUN edge; write-through bypasses the array read
  always_comb begin
    we      = (state_q == CLEAR) || bus.wren;
    wa      = (state_q == CLEAR) ? cnt_q : bus.address;
    wdat    = (state_q == CLEAR) ? CLEAR_VALUE : bus.data;
    ready_d = (state_d == RUN);
    qen_d   = (state_q == RUN);
    hit_d   = (state_q == RUN) && bus.wren;
    wd_d    = bus.data;
  end
  always_ff @(posedge clock) begin
    if (we) mem[wa] <= wdat;
    mem_rd <= mem[bus.address];
  end
  assign bus.q     = qen_q ? (hit_q ? wd_q : mem_rd) : '0;
  assign bus.ready = ready_q;
endmodule

// File: tb/tb_ram_32768x3.sv
// tb_ram_32768x3: directed and random checks of the self-clearing colour RAM against an array model
module tb_ram_32768x3;
  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  logic [2:0] model [32768];
  ram_32768x3_if bus ();
  ram_32768x3 dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic sweep();
    int n = 0;
    reset = 1'b1;
    #1 reset = 1'b0;
    chk("sweep_ready_low", {31'd0, bus.ready}, 0);
    while (!bus.ready && n < 40000) begin
      @(posedge clock);
      @(negedge clock);
      n++;
      if (n == 100) chk("sweep_q_zero", {29'd0, bus.q}, 0);
      if (n == 32767) chk("sweep_not_ready_early", {31'd0, bus.ready}, 0);
    end
    chk("sweep_len", n, 32768);
    for (int i = 0; i < 32768; i++) model[i] = 3'b000;
  endtask
  task automatic op(input string tag, input logic we, input logic [14:0] a, input logic [2:0] d);
    logic [2:0] exp;
    bus.wren = we;
    bus.address = a;
    bus.data = d;
    @(posedge clock);
    @(negedge clock);
    exp = we ? d : model[a];
    if (we) model[a] = d;
    chk(tag, {29'd0, bus.q}, {29'd0, exp});
  endtask
  task automatic rand_ops(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      logic [14:0] a;
      a = ($urandom_range(0, 3) == 0) ? 15'($urandom) : 15'($urandom_range(0, 31));
      op("rand", 1'($urandom), a, 3'($urandom));
    end
  endtask
  initial begin
    reset = 1'b1;
    bus.wren = 1'b0;
    bus.address = '0;
    bus.data = '0;
    repeat (2) @(negedge clock);
    chk("reset_q", {29'd0, bus.q}, 0);
    chk("reset_ready", {31'd0, bus.ready}, 0);
    bus.wren = 1'b1;
    bus.address = 15'h0005;
    bus.data = 3'b111;
    sweep();
    op("read_4f77_clear", 1'b0, 15'h4F77, 3'b000);
    op("write_0001", 1'b1, 15'h0001, 3'b010);
    op("read_0001", 1'b0, 15'h0001, 3'b000);
    op("write_through_4f77", 1'b1, 15'h4F77, 3'b001);
    op("read_4f76", 1'b0, 15'h4F76, 3'b000);
    op("read_0005_ignored_clear_write", 1'b0, 15'h0005, 3'b000);
    op("write_7fff", 1'b1, 15'h7FFF, 3'b110);
    op("write_0000", 1'b1, 15'h0000, 3'b100);
    op("read_7fff", 1'b0, 15'h7FFF, 3'b000);
    op("read_0000", 1'b0, 15'h0000, 3'b000);
    op("read_4f77", 1'b0, 15'h4F77, 3'b000);
    rand_ops(300);
    op("rewrite_7fff", 1'b1, 15'h7FFF, 3'b110);
    op("reread_7fff", 1'b0, 15'h7FFF, 3'b000);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_q", {29'd0, bus.q}, 0);
    chk("async_reset_ready", {31'd0, bus.ready}, 0);
    @(negedge clock);
    bus.wren = 1'b0;
    sweep();
    op("read_7fff_after_resweep", 1'b0, 15'h7FFF, 3'b000);
    op("read_0001_after_resweep", 1'b0, 15'h0001, 3'b000);
    rand_ops(100);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
